// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART framing constants, state encoding and defaults
package uart_pkg;

    // 8N1 framing: start + 8 data + stop
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // Line levels
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // FSM state encoding, shared by transmitter and receiver
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // Board defaults
    localparam int CLOCK_FREQ_DEFAULT = 125_000_000;
    localparam int BAUD_RATE_DEFAULT  = 115_200;

    // Counter width able to hold 0..period-1; never narrower than one bit
    function automatic int counter_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter that pulses on a chosen cycle of each period
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int PERIOD  = 1085,
    parameter int TICK_AT = PERIOD - 1,
    parameter int WIDTH   = counter_width(PERIOD)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(PERIOD - 1);
    localparam logic [WIDTH-1:0] TICK_COUNT = WIDTH'(TICK_AT);

    logic [WIDTH-1:0] count;

    // Count 0..PERIOD-1 while enabled, wrapping at the bit boundary; clear realigns phase
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST_COUNT) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // Transmitter uses the last cycle of the period; a receiver can pick mid-bit
    assign tick = enable && (count == TICK_COUNT);

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 serialiser with valid/ready byte input
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = CLOCK_FREQ_DEFAULT,
    parameter int BAUD_RATE  = BAUD_RATE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out
);

    localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
    localparam int CLOCK_COUNTER_WIDTH = counter_width(SYMBOL_EDGE_TIME);
    localparam int BIT_INDEX_WIDTH     = $clog2(DATA_BITS);
    localparam logic [BIT_INDEX_WIDTH-1:0] LAST_BIT = BIT_INDEX_WIDTH'(DATA_BITS - 1);

    logic [1:0]                 state;
    logic [BIT_INDEX_WIDTH-1:0] bit_index;
    logic [DATA_BITS-1:0]       shreg;
    logic                       fire;
    logic                       bit_tick;

    // Ready depends on state alone so the producer never sees a combinational loop
    assign data_in_ready = (state == IDLE);
    assign fire          = data_in_valid && data_in_ready;

    // Baud counter is held at zero while idle so every frame starts phase-aligned to fire
    uart_baud_tick #(
        .PERIOD  (SYMBOL_EDGE_TIME),
        .TICK_AT (SYMBOL_EDGE_TIME - 1),
        .WIDTH   (CLOCK_COUNTER_WIDTH)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == IDLE),
        .enable  (state != IDLE),
        .tick    (bit_tick)
    );

    // Frame sequencer; serial_out is loaded with the level of the bit about to start
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            serial_out <= IDLE_LEVEL;
            bit_index  <= '0;
            shreg      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        shreg      <= data_in;
                        bit_index  <= '0;
                        serial_out <= START_LEVEL;
                        state      <= START;
                    end else begin
                        serial_out <= IDLE_LEVEL;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        bit_index  <= '0;
                        serial_out <= shreg[0];
                        state      <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_index == LAST_BIT) begin
                            serial_out <= STOP_LEVEL;
                            state      <= STOP;
                        end else begin
                            bit_index  <= bit_index + 1'b1;
                            serial_out <= shreg[bit_index + 1'b1];
                        end
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        serial_out <= IDLE_LEVEL;
                        state      <= IDLE;
                    end
                end
                default: begin
                    serial_out <= IDLE_LEVEL;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter
module tb_uart_transmitter;

    localparam int T  = 10;
    localparam int TB = 1085;

    logic       CLK_125MHZ_FPGA = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;

    logic       rst_big = 1'b1;
    logic [7:0] data_in_big = 8'h00;
    logic       data_in_valid_big = 1'b0;
    logic       data_in_ready_big;
    logic       serial_out_big;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] data;
        int         mode;
        logic [7:0] next;
        logic [9:0] frame;
        string      name;
    } vec_t;

    vec_t vecs[6];

    always #5 CLK_125MHZ_FPGA = ~CLK_125MHZ_FPGA;

    uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
        .clk           (CLK_125MHZ_FPGA),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out)
    );

    uart_transmitter dut_big (
        .clk           (CLK_125MHZ_FPGA),
        .rst           (rst_big),
        .data_in       (data_in_big),
        .data_in_valid (data_in_valid_big),
        .data_in_ready (data_in_ready_big),
        .serial_out    (serial_out_big)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic model_level(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return logic'((b >> (slot - 1)) & 8'h01);
    endfunction

    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic [9:0] f;
        for (int s = 0; s < 10; s++) f[s] = model_level(b, s);
        return f;
    endfunction

    // mode 0: drop valid after fire; 1: hold valid and present next byte; 2: drop valid, scramble data_in
    task automatic run_frame(input logic [7:0] b, input logic [9:0] exp_frame, input int mode,
                             input logic [7:0] next_b, input string name);
        int         lvl_err = 0;
        int         rdy_err = 0;
        int         slot;
        logic [7:0] dec = 8'hxx;
        data_in       = b;
        data_in_valid = 1'b1;
        for (int k = 1; k <= 10 * T; k++) begin
            @(negedge CLK_125MHZ_FPGA);
            slot = (k - 1) / T;
            if (serial_out !== exp_frame[slot]) lvl_err++;
            if (data_in_ready !== 1'b0) rdy_err++;
            if ((k - 1) % T == T / 2 && slot >= 1 && slot <= 8) dec[slot-1] = serial_out;
            if (mode == 1) begin
                if (k == 1) data_in = next_b;
            end else begin
                data_in_valid = 1'b0;
                if (mode == 2) data_in = 8'($urandom);
            end
        end
        check({name, "_levels"}, lvl_err, 0);
        check({name, "_ready_low"}, rdy_err, 0);
        check({name, "_decoded"}, dec, b);
        @(negedge CLK_125MHZ_FPGA);
        check({name, "_after_ready"}, data_in_ready, 1'b1);
        check({name, "_after_line"}, serial_out, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         err;
        int         fall_k;
        int         rise_k;
        int         run_len;
        int         runs[$];
        int         exp_runs[4];
        logic       prev;
        logic [7:0] b;

        vecs[0] = '{8'h41, 0, 8'h00, 10'b1_0100_0001_0, "byte_41"};
        vecs[1] = '{8'h55, 1, 8'hAA, 10'b1_0101_0101_0, "b2b_55"};
        vecs[2] = '{8'hAA, 0, 8'h00, 10'b1_1010_1010_0, "b2b_AA"};
        vecs[3] = '{8'hC3, 2, 8'h00, 10'b1_1100_0011_0, "stable_C3"};
        vecs[4] = '{8'hFF, 0, 8'h00, 10'b1_1111_1111_0, "byte_FF"};
        vecs[5] = '{8'h80, 0, 8'h00, 10'b1_1000_0000_0, "byte_80"};

        // Reset with a pending byte must not start a frame
        rst = 1'b1;
        data_in = 8'hFF;
        data_in_valid = 1'b1;
        err = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK_125MHZ_FPGA);
            if (serial_out !== 1'b1 || data_in_ready !== 1'b1) err++;
        end
        check("reset_hold", err, 0);
        rst = 1'b0;
        data_in_valid = 1'b0;
        err = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK_125MHZ_FPGA);
            if (serial_out !== 1'b1 || data_in_ready !== 1'b1) err++;
        end
        check("reset_idle_50", err, 0);

        // Table-driven frames, including back-to-back and input-stability cases
        for (int v = 0; v < 6; v++)
            run_frame(vecs[v].data, vecs[v].frame, vecs[v].mode, vecs[v].next, vecs[v].name);

        // Reset in the middle of data bit 3
        data_in = 8'hA5;
        data_in_valid = 1'b1;
        for (int k = 1; k <= 4 * T + 5; k++) begin
            @(negedge CLK_125MHZ_FPGA);
            data_in_valid = 1'b0;
        end
        check("midrst_in_bit3", serial_out, 1'b0);
        rst = 1'b1;
        @(negedge CLK_125MHZ_FPGA);
        rst = 1'b0;
        check("midrst_line_idle", serial_out, 1'b1);
        check("midrst_ready", data_in_ready, 1'b1);
        run_frame(8'h00, 10'b1_0000_0000_0, 0, 8'h00, "after_rst_00");

        // Random bytes with random idle gaps against the reference model
        for (int r = 0; r < 6; r++) begin
            b = 8'($urandom);
            err = 0;
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                @(negedge CLK_125MHZ_FPGA);
                if (serial_out !== 1'b1 || data_in_ready !== 1'b1) err++;
            end
            check("rand_gap_idle", err, 0);
            run_frame(b, model_frame(b), int'($urandom_range(0, 1)) * 2, 8'h00, "rand_byte");
        end

        // Default parameters: T = 1085
        rst_big = 1'b0;
        @(negedge CLK_125MHZ_FPGA);
        check("big_idle_ready", data_in_ready_big, 1'b1);
        data_in_big = 8'h0F;
        data_in_valid_big = 1'b1;
        fall_k = -1;
        rise_k = -1;
        err = 0;
        run_len = 0;
        prev = 1'b1;
        for (int k = 1; k <= 10 * TB + 5; k++) begin
            @(negedge CLK_125MHZ_FPGA);
            data_in_valid_big = 1'b0;
            if (k <= 10 * TB && serial_out_big !== model_level(8'h0F, (k - 1) / TB)) err++;
            if (fall_k < 0 && serial_out_big === 1'b0) fall_k = k;
            if (rise_k < 0 && data_in_ready_big === 1'b1) begin
                rise_k = k;
                if (run_len > 0) runs.push_back(run_len);
            end
            if (fall_k > 0 && rise_k < 0) begin
                if (run_len > 0 && serial_out_big !== prev) begin
                    runs.push_back(run_len);
                    run_len = 0;
                end
                run_len++;
                prev = serial_out_big;
            end
        end
        check("big_levels", err, 0);
        check("big_fall_cycle", fall_k, 1);
        check("big_frame_len", rise_k - fall_k, 10 * TB);
        exp_runs = '{TB, 4 * TB, 4 * TB, TB};
        check("big_run_count", runs.size(), 4);
        for (int i = 0; i < 4; i++)
            check("big_run_len", (i < runs.size()) ? runs[i] : -1, exp_runs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
